// File: rtl/branch_predict_unit.sv
// Conditional-branch predictor (2-bit saturating BHT, read in ID) and resolver
// (EX) producing the main_branch flush request, redirect PC and statistics.
module branch_predict_unit #(
  parameter int XLEN    = 32,
  parameter int BHT_IDX = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic            id_is_branch,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_target,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jalr,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  output logic            main_branch,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int BHT_N = 1 << BHT_IDX;

  logic [1:0]         bht_q [BHT_N];
  logic [1:0]         bht_d [BHT_N];
  logic [31:0]        branch_count_q, branch_count_d;
  logic [31:0]        mispredict_count_q, mispredict_count_d;

  logic [BHT_IDX-1:0] id_idx;
  logic [BHT_IDX-1:0] ex_idx;
  logic               res;
  logic               mispredict;
  logic               jalr_v;
  logic               unused_pc_bits;

  assign id_idx = id_pc[BHT_IDX+1:2];
  assign ex_idx = ex_pc[BHT_IDX+1:2];
  assign unused_pc_bits = ^{id_pc[XLEN-1:BHT_IDX+2], id_pc[1:0],
                            ex_pc[XLEN-1:BHT_IDX+2], ex_pc[1:0]};

  assign res         = ex_valid & ex_is_branch;
  assign mispredict  = res & (ex_taken != ex_pred_taken);
  assign jalr_v      = ex_valid & ex_is_jalr;
  assign main_branch = mispredict | jalr_v;

  // ID reads the registered table: no bypass from a same-cycle EX update.
  assign pred_taken  = id_valid & id_is_branch & ~main_branch & bht_q[id_idx][1];
  assign pred_target = id_target;

  always_comb begin
    redirect_pc = '0;
    if (jalr_v) begin
      redirect_pc = ex_target;
    end else if (mispredict && ex_taken) begin
      redirect_pc = ex_target;
    end else if (mispredict) begin
      redirect_pc = ex_pc + XLEN'(4);
    end
  end

  always_comb begin
    for (int i = 0; i < BHT_N; i++) begin
      bht_d[i] = bht_q[i];
    end
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (res) begin
      branch_count_d = branch_count_q + 32'd1;
      if (ex_taken) begin
        if (bht_q[ex_idx] != 2'b11) bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
      end else begin
        if (bht_q[ex_idx] != 2'b00) bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
      end
    end
    if (mispredict) begin
      mispredict_count_d = mispredict_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++) begin
        bht_q[i] <= 2'b01;
      end
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      for (int i = 0; i < BHT_N; i++) begin
        bht_q[i] <= bht_d[i];
      end
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Dynamic conditional-branch predictor and resolver that produces `main_branch`, the flush request consumed by the flush unit. It predicts conditional branches in ID from a 2-bit saturating-counter branch history table (BHT) and resolves them in EX. On a misprediction, or on any `jalr`, it raises `main_branch` and supplies the corrected fetch address. It also keeps branch and mispredict statistics counters.

## Interface

Parameters:
- `XLEN`, 32, address/data width
- `BHT_IDX`, 6, BHT index bits; the table has 2^BHT_IDX entries, indexed by `pc[BHT_IDX+1:2]`

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `id_valid`  in  1  ID stage holds a valid instruction
- `id_is_branch`  in  1  ID instruction is a conditional branch (beq..bgeu)
- `id_pc`  in  XLEN  PC of the ID instruction
- `id_target`  in  XLEN  branch target computed in ID (pc + B-imm)
- `pred_taken`  out  1  prediction for the ID instruction (combinational)
- `pred_target`  out  XLEN  redirect PC for the fetch stage when `pred_taken`=1 (equals `id_target`)
- `ex_valid`  in  1  EX stage holds a valid instruction
- `ex_is_branch`  in  1  EX instruction is a conditional branch
- `ex_is_jalr`  in  1  EX instruction is `jalr`
- `ex_pc`  in  XLEN  PC of the EX instruction
- `ex_taken`  in  1  actual branch outcome from the ALU
- `ex_target`  in  XLEN  actual target (branch target or `jalr` address)
- `ex_pred_taken`  in  1  `pred_taken` value carried down the pipeline with this instruction
- `main_branch`  out  1  flush request to the flush unit (combinational)
- `redirect_pc`  out  XLEN  correct next fetch PC when `main_branch`=1, else 0
- `branch_count`  out  32  number of resolved conditional branches
- `mispredict_count`  out  32  number of conditional-branch mispredictions

## Operation

- **BHT:** 2^BHT_IDX entries × 2 bits. States: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- **Prediction:** `pred_taken` = `id_valid & id_is_branch & ~main_branch & BHT[id_pc idx][1]`.
  - `main_branch` forces the prediction to 0, because the ID instruction is then wrong-path.
  - `pred_target` = `id_target` at all times.
- **Resolution:** let `res` = `ex_valid & ex_is_branch`.
  - `mispredict` = `res & (ex_taken != ex_pred_taken)`.
  - `main_branch` = `mispredict | (ex_valid & ex_is_jalr)`.
- **`redirect_pc` priority:**
  1. `jalr`: `ex_target`
  2. mispredicted taken: `ex_target`
  3. mispredicted not-taken: `ex_pc + 4`
  4. otherwise 0
- **BHT update:** when `res`=1, the entry at `ex_pc` index saturates toward the outcome at the clock edge.
  - Taken: +1, capped at 11.
  - Not-taken: −1, floored at 00.
  - `jalr` and non-branches never touch the BHT.
- **Read/write collision:** same index in the same cycle has no bypass. ID reads the pre-update value.
- **Counters:**
  - `branch_count` += 1 on every `res`.
  - `mispredict_count` += 1 on every `mispredict`.
  - Both wrap modulo 2^32.
- **Reset (`rst_n`=0 at an edge):**
  - Every BHT entry becomes 01; both counters become 0.
  - Combinational outputs keep following their inputs; the pipeline is expected to drive the valids to 0 during reset.
  - Reset asserted mid-operation discards any pending update in that cycle. Reset wins over the update.

## Timing

- **Prediction:** `pred_taken` valid in the same cycle as the ID inputs; zero latency.
- **Flush:** `main_branch`/`redirect_pc` valid in the same cycle as the EX inputs. The flush unit and PC mux consume them before the next edge.
- **BHT:** update visible to ID reads from the cycle after resolution (1-cycle latency).
- **Counters:** update visible 1 cycle after the resolving EX cycle.
- **Aliasing:** two PCs sharing an index share an entry. No tags.
- **Back-to-back branches:** same entry resolved in consecutive cycles applies two sequential saturating steps.
- **Reset values:** BHT = 01 (all entries), `branch_count` = 0, `mispredict_count` = 0. With all valids at 0: `pred_taken` = 0, `main_branch` = 0, `redirect_pc` = 0.

## Test plan

- **Reset and cold predict:** release reset; branch at `id_pc`=0x100 in ID → `pred_taken`=0; `branch_count`=0, `mispredict_count`=0.
- **Training:** resolve taken branch at `ex_pc`=0x100 with `ex_pred_taken`=0, `ex_target`=0x80.
  - Same cycle: `main_branch`=1, `redirect_pc`=0x80.
  - Next cycle: `pred_taken`=1 for `id_pc`=0x100; `mispredict_count`=1.
- **Saturation:** resolve 0x100 taken 4× more, then not-taken once.
  - Entry goes 11 → 10, and `pred_taken` stays 1.
  - The not-taken resolve with `ex_pred_taken`=1 gives `redirect_pc`=0x104.
- **jalr:** `ex_is_jalr`=1, `ex_target`=0x2000.
  - `main_branch`=1, `redirect_pc`=0x2000.
  - BHT and counters unchanged.
- **Simultaneous ID/EX same index:** mispredict at EX while ID holds a branch.
  - `pred_taken`=0 (squashed); ID reads the old entry (no bypass).
  - A correct-prediction resolve gives `main_branch`=0.
- **Reset mid-run:** after training 0x100 to 11 and counters nonzero, pulse `rst_n`=0 for one cycle together with a resolving branch.
  - Entry becomes 01, counters become 0; the update is discarded.
